serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: a bit-serial adder that processes 2 bits per clock.
// An accepted operand pair is added over WIDTH/2 RUN cycles by a single
// 2-bit slice adder. The result is then held in DONE until the consumer
// takes it.
//
// Optional feature: define SERIAL_ADD_SIGNED_OVF_EN to add the `ovf` output.
// `ovf` flags two's-complement overflow of a+b and is valid with out_valid.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. Input side: in_ready is high only in IDLE.
// Output side: out_valid is high only in DONE, and sum/ovf stay stable
// until out_ready is seen.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy,
`ifdef SERIAL_ADD_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       o_dbg_state
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH:0]   r_sum;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [1:0]       w_x;
    logic [1:0]       w_y;
    logic [2:0]       w_res;

    // Select the current 2-bit slice of each operand. The slice adder is
    // the only adder in the datapath.
    always_comb begin
        w_a_sh   = r_a >> {r_idx, 1'b0};
        w_b_sh   = r_b >> {r_idx, 1'b0};
        w_x      = w_a_sh[1:0];
        w_y      = w_b_sh[1:0];
        w_res    = {1'b0, w_x} + {1'b0, w_y} + {2'b00, r_carry};
        w_last   = (r_idx == LAST_IDX);
        w_accept = in_valid && in_ready;
    end

    // Next-state logic and handshake outputs, decoded from the current state.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register. Reset wins over any handshake seen on the same edge.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Datapath: capture operands on accept, then add one slice per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum[{r_idx, 1'b0} +: 2] <= w_res[1:0];
            r_carry                   <= w_res[2];
            r_idx                     <= r_idx + 1'b1;
            if (w_last) r_sum[WIDTH] <= w_res[2];
        end
    end

`ifdef SERIAL_ADD_SIGNED_OVF_EN
    logic r_ovf;

    // Signed overflow is resolved on the last slice. That slice produces
    // sum[WIDTH-1] from the operand MSBs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_RUN && w_last) begin
            r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[1] != r_a[WIDTH-1]);
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum         = r_sum;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl with WIDTH=8.
// It applies directed vectors from a table, then random operations. Both are
// checked against a plain-arithmetic model of a+b. It also runs hand-written
// reset and abort sequences. The ovf checks are enabled by
// SERIAL_ADD_SIGNED_OVF_EN.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         busy;
  logic [1:0]   dbg_state;
`ifdef SERIAL_ADD_SIGNED_OVF_EN
  logic         ovf;
`endif

  int checks;
  int failures;

  logic [W:0] exp_q[$];
  logic       ovf_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   sum;
    logic         ovf;
    int           stall;
    bit           hold;
  } vec_t;

  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .busy       (busy),
`ifdef SERIAL_ADD_SIGNED_OVF_EN
    .ovf        (ovf),
`endif
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // driver: one complete operation with optional DONE stall and optional
  // in_valid held high (with scrambled operands) while the DUT is busy
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W:0] esum, input logic eovf,
                        input int stall, input bit hold);
    int         lat;
    logic [W:0] exp_s;
    logic       exp_o;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    out_ready = 1'($urandom_range(0, 1));
    exp_q.push_back(esum);
    ovf_q.push_back(eovf);
    @(negedge clk);
    lat      = 1;
    in_valid = hold;
    while (!out_valid && lat < 20) begin
      check("in_ready_run", 32'(in_ready), 32'd0);
      check("busy_run", 32'(busy), 32'd1);
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd5);
    check("out_valid_done", 32'(out_valid), 32'd1);
    exp_s = exp_q.pop_front();
    exp_o = ovf_q.pop_front();
    out_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(sum), 32'(exp_s));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("sum", 32'(sum), 32'(exp_s));
`ifdef SERIAL_ADD_SIGNED_OVF_EN
    check("ovf", 32'(ovf), 32'(exp_o));
`endif
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sum_hold", 32'(sum), 32'(exp_s));
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           ss;
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    vecs[0] = '{8'h0F, 8'h01, 9'h010, 1'b0, 0, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 9'h1FE, 1'b0, 0, 1'b0};
    vecs[2] = '{8'h12, 8'h34, 9'h046, 1'b0, 3, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 9'h000, 1'b0, 1, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 9'h0FF, 1'b0, 0, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 9'h100, 1'b1, 2, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 9'h080, 1'b1, 0, 1'b0};
    vecs[7] = '{8'hFF, 8'h01, 9'h100, 1'b0, 0, 1'b1};

    // reset state
    do_reset(2);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
`ifdef SERIAL_ADD_SIGNED_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif

    // directed table
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].ovf, vecs[i].stall, vecs[i].hold);

    // random operations against an arithmetic model
    for (int i = 0; i < 25; i++) begin
      int sv;
      ra = W'($urandom);
      rb = W'($urandom);
      sv = int'($signed(ra)) + int'($signed(rb));
      ss = $urandom_range(0, 3);
      run_op(ra, rb, (W+1)'(int'(ra) + int'(rb)), (sv > 127) || (sv < -128),
             ss, 1'($urandom_range(0, 1)));
    end

    // reset during RUN slice 2: result must be discarded
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h5A;
    b        = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_result", 32'(out_valid), 32'd0);
    end

    // reset wins over a simultaneous accept
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_prio_in_ready", 32'(in_ready), 32'd1);
    check("rst_prio_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst_prio_no_accept", 32'(busy), 32'd0);

    // machine is still usable after the abort
    run_op(8'hC3, 8'h3D, 9'h100, 1'b0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
